// File: rtl/poly_coeff_loader.sv
// Streams one polynomial (N = 2^(HLEN+1) coefficients) into an even/odd bank pair.
// Define COEFF_REDUCE_EN to apply a single conditional subtract of Q to each coefficient.
module poly_coeff_loader #(
  parameter int DLEN = 32,
  parameter int HLEN = 7,
  parameter int Q    = 3329
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            poly_sel,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DLEN-1:0] in_data,
  input  logic            in_last,
  output logic [3:0]      bank_en,
  output logic [3:0]      bank_we,
  output logic [HLEN-1:0] bank_addr,
  output logic [DLEN-1:0] bank_di,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [HLEN:0] IDX_ONE = (HLEN+1)'(1);

  state_t          state_reg, state_next;
  logic [HLEN:0]   idx_reg, idx_next;
  logic            sel_reg, sel_next;
  logic            err_reg, err_next;
  logic            done_reg;
  logic [3:0]      en_reg;
  logic [3:0]      en_next;
  logic [HLEN-1:0] addr_reg;
  logic [DLEN-1:0] di_reg;
  logic [DLEN-1:0] coef_w;
  logic            beat_acc;
  logic            last_idx;

  assign beat_acc = (state_reg == LOAD) && in_valid;
  assign last_idx = &idx_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      sel_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      sel_reg   <= sel_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    sel_next   = sel_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          idx_next   = '0;
          sel_next   = poly_sel;
          err_next   = 1'b0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          idx_next = idx_reg + IDX_ONE;
          // in_last must be high exactly on the final beat; it never shortens the load
          if (in_last != last_idx) begin
            err_next = 1'b1;
          end
          if (last_idx) begin
            state_next = FLUSH;
          end
        end
      end
      FLUSH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Even indices go to the lower bank of the pair, odd indices to the upper one
  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    localparam logic [1:0] BANK_ID = 2'(gi);
    assign en_next[gi] = beat_acc && ({sel_reg, idx_reg[0]} == BANK_ID);
  end

`ifdef COEFF_REDUCE_EN
  localparam logic [DLEN-1:0] Q_W = DLEN'(Q);
  assign coef_w = (in_data >= Q_W) ? (in_data - Q_W) : in_data;
`else
  assign coef_w = in_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      en_reg   <= '0;
      addr_reg <= '0;
      di_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      en_reg   <= en_next;
      done_reg <= (state_reg == FLUSH);
      if (beat_acc) begin
        addr_reg <= idx_reg[HLEN:1];
        di_reg   <= coef_w;
      end
    end
  end

  assign in_ready  = (state_reg == LOAD);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign err       = err_reg;
  assign bank_en   = en_reg;
  assign bank_we   = en_reg;
  assign bank_addr = addr_reg;
  assign bank_di   = di_reg;

endmodule

// File: doc/poly_coeff_loader.md
POLY_COEFF_LOADER -- requirements
Module: poly_coeff_loader

Interface
REQ-001 Parameter DLEN, default 32, coefficient width in bits.
REQ-002 Parameter HLEN, default 7, bank address width; bank depth is 2^HLEN; polynomial length is N = 2^(HLEN+1).
REQ-003 Parameter Q, default 3329, coefficient modulus, Q < 2^DLEN.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin loading one polynomial.
REQ-007 poly_sel  in  1  target bank pair: 0 selects banks {0,1}; 1 selects banks {2,3}.
REQ-008 in_valid  in  1  coefficient beat valid.
REQ-009 in_ready  out  1  loader accepts a beat this cycle.
REQ-010 in_data  in  DLEN  coefficient value, in natural index order 0..N-1.
REQ-011 in_last  in  1  producer marks the final beat.
REQ-012 bank_en  out  4  one-hot bank enable, drives bank port-A en.
REQ-013 bank_we  out  4  one-hot bank write enable; equals bank_en.
REQ-014 bank_addr  out  HLEN  port-A write address.
REQ-015 bank_di  out  DLEN  port-A write data.
REQ-016 busy  out  1  load in progress.
REQ-017 done  out  1  one-cycle pulse on load completion.
REQ-018 err  out  1  sticky framing error for the current load.

Function
REQ-019 FSM states: IDLE, LOAD, FLUSH; IDLE->LOAD on start; LOAD->FLUSH on acceptance of beat N-1; FLUSH->IDLE after one cycle.
REQ-020 poly_sel is sampled on the cycle start is accepted and held constant for the whole load.
REQ-021 start is ignored in LOAD and FLUSH.
REQ-022 in_ready is 1 only in LOAD; a beat is accepted when in_valid and in_ready are both 1; in_valid low stalls without loss.
REQ-023 Index counter idx (HLEN+1 bits) clears on start acceptance and increments by 1 per accepted beat.
REQ-024 A beat accepted at cycle t with index i produces, at cycle t+1, a one-hot bank_en/bank_we on bank 2*poly_sel + i[0], bank_addr = i >> 1, and bank_di = the coefficient.
REQ-025 bank_en, bank_we, bank_addr and bank_di are registered; bank_en and bank_we are all-zero on every cycle that follows a cycle with no accepted beat.
REQ-026 busy is 1 from the cycle after start is accepted through the FLUSH cycle inclusive.
REQ-027 done pulses for exactly one cycle, in the cycle after FLUSH, coincident with busy falling.
REQ-028 err clears on start acceptance and sets if in_last=1 on a beat with i != N-1, or if in_last=0 on beat N-1.
REQ-029 The load always consumes exactly N beats regardless of in_last; err is stable while done is high.
REQ-030 The loader never drives two banks in the same cycle and never issues a read-only enable.

Reset
REQ-031 reset forces state IDLE, idx 0, in_ready 0, bank_en 0, bank_we 0, bank_addr 0, bank_di 0, busy 0, done 0, err 0.
REQ-032 reset asserted mid-load aborts the load immediately: no further writes, and done does not pulse.
REQ-033 reset takes priority over start in the same cycle.

Configuration
REQ-034 Macro COEFF_REDUCE_EN.
- Defined: bank_di = in_data - Q when in_data >= Q, otherwise in_data (single conditional subtract).
- Undefined: bank_di = in_data unmodified.
- Latency and handshake are identical in both builds.

Verification
REQ-035 HLEN=2, poly_sel=0, start, 8 back-to-back beats 10..17 with in_last on beat 7:
- bank0 addr 0..3 receives 10, 12, 14, 16; bank1 addr 0..3 receives 11, 13, 15, 17.
- Each write follows its accepted beat by one cycle.
- done pulses one cycle after FLUSH; err=0.
REQ-036 poly_sel=1, in_valid toggled 1,0,1,0 throughout the load:
- Writes land only in banks 2 and 3, with addresses as in REQ-035.
- bank_en=0 on the cycle after each stall; no beat is dropped.
REQ-037 in_last asserted on beat 3 of 8:
- All 8 beats are still written; err=1 at done.
- err clears on the next start.
REQ-038 reset pulsed after beat 4 is accepted:
- No write occurs after the reset cycle; done stays 0; busy=0 and in_ready=0 on the following cycle.
REQ-039 start asserted during LOAD is ignored: idx is not disturbed, and exactly one done pulse occurs.
REQ-040 With COEFF_REDUCE_EN defined, Q=3329:
- inputs 3328, 3329 and 6000 are written as 3328, 0 and 2671.
- Without the macro, the same inputs are written unchanged.
